// File: rtl/booth_mult.sv
// booth_mult: sequential radix-2 Booth signed multiplier, one Booth step per clock.
// Produces the 2*WIDTH-bit product of RegAOut * RegBOut on MultHIOut/MultLOOut.
// Optional feature macro: MULT_OVF_FLAG_EN adds MultOvf, set when the product
// does not fit in WIDTH signed bits.
module booth_mult #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] RegAOut,
    input  logic [WIDTH-1:0] RegBOut,
    input  logic             MultCtrl,
    output logic             MultDone,
    output logic [WIDTH-1:0] MultHIOut,
    output logic [WIDTH-1:0] MultLOOut
`ifdef MULT_OVF_FLAG_EN
    ,
    output logic             MultOvf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [WIDTH:0]    acc_r;
    logic [WIDTH:0]    m_r;
    logic [WIDTH-1:0]  q_r;
    logic              q1_r;
    logic [CW-1:0]     cnt_r;
    logic              done_r;
    logic [WIDTH-1:0]  hi_r;
    logic [WIDTH-1:0]  lo_r;

    logic [WIDTH:0]    sum_s;
    logic [WIDTH:0]    acc_sh_s;
    logic [WIDTH-1:0]  q_sh_s;
    logic              q1_sh_s;
    logic              last_step_s;

`ifdef MULT_OVF_FLAG_EN
    logic              ovf_r;

    // Product overflows WIDTH signed bits when the high half is not a pure sign extension of the low half.
    function automatic logic ovf_calc(input logic [WIDTH-1:0] hi, input logic [WIDTH-1:0] lo);
        return (hi != {WIDTH{lo[WIDTH-1]}});
    endfunction
`endif

    // Booth add/subtract on {Q[0],q_1}, then arithmetic right shift of {Acc,Q,q_1}.
    always_comb begin
        sum_s = acc_r;
        case ({q_r[0], q1_r})
            2'b01:   sum_s = acc_r + m_r;
            2'b10:   sum_s = acc_r - m_r;
            default: sum_s = acc_r;
        endcase
        acc_sh_s    = {sum_s[WIDTH], sum_s[WIDTH:1]};
        q_sh_s      = {sum_s[0], q_r[WIDTH-1:1]};
        q1_sh_s     = q_r[0];
        last_step_s = (cnt_r == CW'(WIDTH - 1));
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: start on request, abort whenever the request drops.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (MultCtrl) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (!MultCtrl) begin
                    state_s = IDLE;
                end else if (last_step_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (MultCtrl) begin
                    state_s = DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Datapath: operand load at start, one Booth step per RUN edge, result capture on the last step.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_r  <= '0;
            m_r    <= '0;
            q_r    <= '0;
            q1_r   <= 1'b0;
            cnt_r  <= '0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
`ifdef MULT_OVF_FLAG_EN
            ovf_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (MultCtrl) begin
                        acc_r  <= '0;
                        m_r    <= {RegAOut[WIDTH-1], RegAOut};
                        q_r    <= RegBOut;
                        q1_r   <= 1'b0;
                        cnt_r  <= '0;
                        done_r <= 1'b0;
`ifdef MULT_OVF_FLAG_EN
                        ovf_r  <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (MultCtrl) begin
                        acc_r <= acc_sh_s;
                        q_r   <= q_sh_s;
                        q1_r  <= q1_sh_s;
                        cnt_r <= cnt_r + CW'(1);
                        if (last_step_s) begin
                            hi_r   <= acc_sh_s[WIDTH-1:0];
                            lo_r   <= q_sh_s;
                            done_r <= 1'b1;
`ifdef MULT_OVF_FLAG_EN
                            ovf_r  <= ovf_calc(acc_sh_s[WIDTH-1:0], q_sh_s);
`endif
                        end
                    end
                end
                DONE: begin
                    if (!MultCtrl) begin
                        done_r <= 1'b0;
                    end
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign MultDone  = done_r;
    assign MultHIOut = hi_r;
    assign MultLOOut = lo_r;
`ifdef MULT_OVF_FLAG_EN
    assign MultOvf   = ovf_r;
`endif

endmodule

// File: tb/tb_booth_mult.sv
// tb_booth_mult: scoreboard bench for booth_mult. Expected products come from
// plain signed arithmetic; a monitor pops them when MultDone rises.
module tb_booth_mult;

    localparam int W = 32;

    logic          clock;
    logic          reset;
    logic [W-1:0]  RegAOut;
    logic [W-1:0]  RegBOut;
    logic          MultCtrl;
    logic          MultDone;
    logic [W-1:0]  MultHIOut;
    logic [W-1:0]  MultLOOut;
`ifdef MULT_OVF_FLAG_EN
    logic          MultOvf;
`endif

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    booth_mult #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .RegAOut   (RegAOut),
        .RegBOut   (RegBOut),
        .MultCtrl  (MultCtrl),
        .MultDone  (MultDone),
        .MultHIOut (MultHIOut),
        .MultLOOut (MultLOOut)
`ifdef MULT_OVF_FLAG_EN
        ,
        .MultOvf   (MultOvf)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: exact signed product.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        e.hi  = p[63:32];
        e.lo  = p[31:0];
        e.ovf = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        return e;
    endfunction

    // Monitor: every rising MultDone must match the oldest outstanding expectation.
    logic done_q = 1'b0;
    always @(negedge clock) begin
        if (MultDone && !done_q) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(MultDone), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_hi", 64'(MultHIOut), 64'(e.hi));
                check("sb_lo", 64'(MultLOOut), 64'(e.lo));
`ifdef MULT_OVF_FLAG_EN
                check("sb_ovf", 64'(MultOvf), 64'(e.ovf));
`endif
            end
        end
        done_q = MultDone;
    end

    // Full operation: start, latency check, scramble operands, hold, release.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        exp_t e;
        int   n;
        e = model(a, b);
        @(posedge clock); #2;
        RegAOut  = a;
        RegBOut  = b;
        MultCtrl = 1'b1;
        exp_q.push_back(e);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            if (i == 1) begin
                RegAOut = $urandom;
                RegBOut = $urandom;
            end
            if (MultDone) begin
                n = i;
                break;
            end
        end
        check("latency", 64'(n), 64'd33);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
        end
        if (hold > 0) begin
            check("hold_done", 64'(MultDone), 64'd1);
            check("hold_hi", 64'(MultHIOut), 64'(e.hi));
            check("hold_lo", 64'(MultLOOut), 64'(e.lo));
        end
        MultCtrl = 1'b0;
        @(posedge clock); #1;
        check("release_done", 64'(MultDone), 64'd0);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           rises;
        reset    = 1'b1;
        MultCtrl = 1'b0;
        RegAOut  = '0;
        RegBOut  = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_done", 64'(MultDone), 64'd0);
        check("rst_hi", 64'(MultHIOut), 64'd0);
        check("rst_lo", 64'(MultLOOut), 64'd0);
`ifdef MULT_OVF_FLAG_EN
        check("rst_ovf", 64'(MultOvf), 64'd0);
`endif
        reset = 1'b0;

        // Directed products; the first holds 10 cycles after DONE (no restart).
        run_op(32'd7, 32'd3, 10);
        run_op(32'hFFFFFFF9, 32'd3, 2);
        run_op(32'h80000000, 32'h80000000, 2);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(32'h00010000, 32'h00010000, 1);

        // Reset in the middle of a run.
        @(posedge clock); #2;
        RegAOut  = 32'd9;
        RegBOut  = 32'd9;
        MultCtrl = 1'b1;
        repeat (11) @(posedge clock);
        #2;
        reset    = 1'b1;
        MultCtrl = 1'b0;
        @(posedge clock); #1;
        check("midrst_done", 64'(MultDone), 64'd0);
        check("midrst_hi", 64'(MultHIOut), 64'd0);
        check("midrst_lo", 64'(MultLOOut), 64'd0);
        reset = 1'b0;
        run_op(32'd5, 32'd6, 1);

        // Abort mid run: result registers keep the prior 5*6 product, no done.
        @(posedge clock); #2;
        RegAOut  = 32'd11;
        RegBOut  = 32'd13;
        MultCtrl = 1'b1;
        repeat (13) @(posedge clock);
        #2;
        MultCtrl = 1'b0;
        @(posedge clock); #1;
        check("abort_done", 64'(MultDone), 64'd0);
        check("abort_hi", 64'(MultHIOut), 64'd0);
        check("abort_lo", 64'(MultLOOut), 64'd30);
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (MultDone) rises++;
        end
        check("abort_idle", 64'(rises), 64'd0);

        // Randomized operands, with occasional zeros and extreme values.
        for (int k = 0; k < 20; k++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0:       a = '0;
                1:       b = '0;
                2:       a = 32'h80000000;
                default: ;
            endcase
            run_op(a, b, $urandom_range(0, 3));
        end

        repeat (3) @(posedge clock);
        #1;
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
